seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier, the clocked successor to the 4-bit combinational array multiplier in this arithmetic library. It computes a full 2·WIDTH-bit product of two WIDTH-bit operands, one partial product per clock, with a start/done handshake. It supports unsigned and two's-complement signed modes, selected per operation. It trades the array multiplier's area for WIDTH+1 cycles of latency and is the building block for wider datapaths in later assignments.

---
 rtl/seq_multiplier.sv | 104 ++++++++++
 tb/tb_seq_multiplier.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, full 2*WIDTH-bit result.
// Signed mode multiplies operand magnitudes and negates the result when the operand signs differ.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    addend;

  // The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign a_mag  = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag  = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches);
    // combinational logic uses blocking '=', the state register below uses non-blocking '<='.
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + addend;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Load the result from this edge's accumulator value so the last partial product is included.
          product_d = neg_q ? (~acc_d + PW'(1)) : acc_d;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 8-bit vector table, held-start, mid-run reset,
// plus an exhaustive sweep of a 4-bit instance in both modes.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int checks   = 0;
  int failures = 0;
  int done4_cnt = 0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(p4)
  );

  always @(negedge clk) if (done4) done4_cnt++;

  typedef struct {
    string       name;
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start at one negedge; k counts edges after the start edge, done is expected once k reaches 8.
  task automatic op8(input string name, input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    logic [15:0] prev;
    int k;
    bit seen;
    prev = p8;
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; sm8 = ~sm; a8 = 8'($urandom); b8 = 8'($urandom);
    check({name, " busy_after_start"}, 32'(busy8), 32'd1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (done8) seen = 1'b1;
      else begin
        if (p8 !== prev) check({name, " product_hold"}, 32'(p8), 32'(prev));
        @(negedge clk);
        k++;
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    check({name, " latency"}, 32'(k), 32'd8);
    check({name, " product"}, 32'(p8), 32'(exp));
    check({name, " busy_in_done"}, 32'(busy8), 32'd1);
    @(negedge clk);
    check({name, " done_one_cycle"}, {30'd0, busy8, done8}, 32'd0);
  endtask

  task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int k;
    @(negedge clk);
    start4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    k = 0;
    while (!done4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("w4 sm=%0d %0h*%0h latency", sm, a, b), 32'(k), 32'd4);
    check($sformatf("w4 sm=%0d %0h*%0h product", sm, a, b), 32'(p4), 32'(exp));
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{"s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{"s_80_7f", 1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[3]  = '{"u_00_ab", 1'b0, 8'h00, 8'hAB, 16'h0000};
    vecs[4]  = '{"u_03_05", 1'b0, 8'h03, 8'h05, 16'h000F};
    vecs[5]  = '{"s_ff_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[6]  = '{"s_ff_01", 1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[7]  = '{"u_80_7f", 1'b0, 8'h80, 8'h7F, 16'h3F80};
    vecs[8]  = '{"s_7f_7f", 1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[9]  = '{"u_0c_0a", 1'b0, 8'h0C, 8'h0A, 16'h0078};
    vecs[10] = '{"s_05_fd", 1'b1, 8'h05, 8'hFD, 16'hFFF1};
    vecs[11] = '{"u_ff_80", 1'b0, 8'hFF, 8'h80, 16'h7F80};

    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    rst_n = 1'b0;
    #12;
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset product", 32'(p8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    foreach (vecs[i]) op8(vecs[i].name, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Product holds while idle
    repeat (5) @(negedge clk);
    check("idle product_hold", 32'(p8), 32'h7F80);

    // Start held high: only operands presented during IDLE are used
    begin
      logic [15:0] q[$];
      int dones, last, cyc, guard;
      dones = 0; last = -1; cyc = 0;
      @(negedge clk);
      start8 = 1'b1; sm8 = 1'b0;
      while (dones < 3 && cyc < 200) begin
        if (done8) begin
          check("held product", 32'(p8), 32'(q.pop_front()));
          if (last >= 0) check("held period", 32'(cyc - last), 32'd10);
          last = cyc;
          dones++;
        end
        if (!busy8) begin
          a8 = 8'(cyc * 3 + 1);
          b8 = 8'(cyc + 7);
          q.push_back({8'h00, a8} * {8'h00, b8});
        end else begin
          a8 = 8'($urandom); b8 = 8'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
      check("held done_count", 32'(dones), 32'd3);
      start8 = 1'b0;
      guard = 0;
      while (busy8 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("held drain", 32'(busy8), 32'd0);
    end

    // Reset mid-RUN aborts with no done pulse
    begin
      bit saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      start8 = 1'b1; sm8 = 1'b0; a8 = 8'h55; b8 = 8'h66;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (done8) saw_done = 1'b1;
      end
      check("pre_reset busy", 32'(busy8), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset busy", 32'(busy8), 32'd0);
      check("async_reset done", 32'(done8), 32'd0);
      check("async_reset product", 32'(p8), 32'd0);
      check("no_done_before_reset", 32'(saw_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("after_reset product", 32'(p8), 32'd0);
      op8("post_reset_3x5", 1'b0, 8'd3, 8'd5, 16'd15);
    end

    // Exhaustive 4-bit, unsigned then signed
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          logic [3:0] ia, ib;
          logic [7:0] e;
          ia = 4'(i);
          ib = 4'(j);
          if (s == 0) e = {4'h0, ia} * {4'h0, ib};
          else        e = 8'($signed({{4{ia[3]}}, ia}) * $signed({{4{ib[3]}}, ib}));
          op4(s[0], ia, ib, e);
        end
      end
    end
    @(negedge clk);
    check("w4 done_pulse_count", 32'(done4_cnt), 32'd512);
    check("w4 15x15", 32'(p4), 32'h01);
    op4(1'b0, 4'hF, 4'hF, 8'hE1);
    op4(1'b1, 4'h8, 4'h7, 8'hC8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
